// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Holds default widths, the arbiter FSM state type and the late-result entry.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 5;

    typedef enum logic {
        NORMAL = 1'b0,
        STARVE = 1'b1
    } wb_arb_state_t;

    typedef struct packed {
        logic [WB_REG_AW-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_late_fifo.sv
// First-word-fall-through FIFO that parks late results until a write-port slot frees up.
// Ports: CLK, RESET (async, active-low), i_push/i_data in, i_pop in,
//   o_head (current head), o_count, o_full, o_empty.
module wb_late_fifo
    import wb_pkg::*;
#(
    parameter type T     = wb_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Guard both sides so a misbehaving caller cannot corrupt the count.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage carries no reset; validity is defined by the pointers/count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_write_port_arbiter.sv
// Shares the register-file write port between the in-order pipe and late results.
// Ports: CLK, RESET (async, active-low); pipe do_writeback1/writeRegister1/writeData1;
//   late_valid/late_reg/late_data with late_ready; registered rf_we/rf_waddr/rf_wdata;
//   stall_pipe (one-bubble request) and sticky proto_err.
module wb_write_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int REG_AW       = WB_REG_AW,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              do_writeback1,
    input  logic [REG_AW-1:0] writeRegister1,
    input  logic [DATA_W-1:0] writeData1,
    input  logic              late_valid,
    input  logic [REG_AW-1:0] late_reg,
    input  logic [DATA_W-1:0] late_data,
    output logic              late_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall_pipe,
    output logic              proto_err
);

    localparam int CW   = $clog2(DEPTH+1);
    localparam int AGEW = $clog2(STARVE_LIMIT+1);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    wb_arb_state_t r_state;
    wb_arb_state_t w_state_nxt;

    logic [AGEW-1:0]   r_age;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_stall;
    logic              r_proto_err;

    logic              w_pw;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_at_depth;
    logic              w_age_hit;
    logic [CW-1:0]     w_count;
    entry_t            w_in;
    entry_t            w_head;

    // Register 0 is hardwired, so a write to it never claims the port.
    assign w_pw = do_writeback1 && (writeRegister1 != '0);

    assign late_ready = !w_full;

    // Results aimed at register 0 complete the handshake but are dropped.
    assign w_push = late_valid && late_ready && (late_reg != '0);

    // The pipe always owns the port; the FIFO only fills idle slots.
    assign w_pop = !w_empty && !w_pw;

    assign w_in.rd   = late_reg;
    assign w_in.data = late_data;

    wb_late_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_at_depth = (w_count == CW'(DEPTH));
    assign w_age_hit  = (r_age == AGEW'(STARVE_LIMIT - 1));

    // A full FIFO escalates immediately since the source is already blocked.
    always_comb begin
        w_state_nxt = r_state;
        unique case (1'b1)
            (r_state == NORMAL): begin
                if (!w_empty && (w_age_hit || w_at_depth)) begin
                    w_state_nxt = STARVE;
                end
            end
            (r_state == STARVE): begin
                if (w_pop || w_empty) begin
                    w_state_nxt = NORMAL;
                end
            end
            default: w_state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= NORMAL;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stall <= (w_state_nxt == STARVE);
        end
    end

    // Head age saturates so it can never wrap back below the limit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_age <= '0;
        end else if (w_pop || w_empty) begin
            r_age <= '0;
        end else if (r_age != AGEW'(STARVE_LIMIT)) begin
            r_age <= r_age + AGEW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_pw || w_pop;
            if (w_pw) begin
                r_rf_waddr <= writeRegister1;
                r_rf_wdata <= writeData1;
            end else if (w_pop) begin
                r_rf_waddr <= w_head.rd;
                r_rf_wdata <= w_head.data;
            end
        end
    end

    // A pipe write during a requested bubble is still honoured but flagged.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_proto_err <= 1'b0;
        end else if (w_pw && r_stall) begin
            r_proto_err <= 1'b1;
        end
    end

    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign stall_pipe = r_stall;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_wb_write_port_arbiter.sv
// Self-checking bench for the write-port arbiter.
// Scoreboard queues hold expected pipe and late writes; a monitor pops them.
module tb_wb_write_port_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        do_writeback1;
    logic [4:0]  writeRegister1;
    logic [31:0] writeData1;
    logic        late_valid;
    logic [4:0]  late_reg;
    logic [31:0] late_data;
    logic        late_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_pipe;
    logic        proto_err;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t pipe_q[$];
    exp_t late_q[$];
    exp_t m_e;

    wb_write_port_arbiter dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .do_writeback1  (do_writeback1),
        .writeRegister1 (writeRegister1),
        .writeData1     (writeData1),
        .late_valid     (late_valid),
        .late_reg       (late_reg),
        .late_data      (late_data),
        .late_ready     (late_ready),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .stall_pipe     (stall_pipe),
        .proto_err      (proto_err)
    );

    always #5 CLK = ~CLK;

    // Pipe writes must appear exactly one edge later; otherwise any write
    // must be the oldest outstanding late result.
    always @(posedge CLK) begin
        #1;
        if (mon_en) begin
            if (pipe_q.size() != 0) begin
                m_e = pipe_q.pop_front();
                checks++;
                if (rf_we !== 1'b1 || rf_waddr !== m_e.rd || rf_wdata !== m_e.data) begin
                    errors++;
                    $display("FAIL pipe_write: got we=%0b reg=%0d data=%h, expected we=1 reg=%0d data=%h",
                             rf_we, rf_waddr, rf_wdata, m_e.rd, m_e.data);
                end
            end else if (rf_we === 1'b1) begin
                checks++;
                if (late_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_write: got reg=%0d data=%h, expected no write",
                             rf_waddr, rf_wdata);
                end else begin
                    m_e = late_q.pop_front();
                    if (rf_waddr !== m_e.rd || rf_wdata !== m_e.data) begin
                        errors++;
                        $display("FAIL late_order: got reg=%0d data=%h, expected reg=%0d data=%h",
                                 rf_waddr, rf_wdata, m_e.rd, m_e.data);
                    end
                end
            end
        end
    end

    // Drives one cycle of stimulus and records expected writes.
    task automatic step(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                        input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                        output bit acc);
        exp_t e;
        @(negedge CLK);
        do_writeback1  = we;
        writeRegister1 = wr;
        writeData1     = wd;
        late_valid     = lv;
        late_reg       = lr;
        late_data      = ld;
        acc = lv && (late_ready === 1'b1);
        if (we && wr != 0) begin
            e.rd = wr; e.data = wd;
            pipe_q.push_back(e);
        end
        if (acc && lr != 0) begin
            e.rd = lr; e.data = ld;
            late_q.push_back(e);
        end
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        do_writeback1 = 0; writeRegister1 = 0; writeData1 = 0;
        late_valid = 0; late_reg = 0; late_data = 0;
        #3;
        checks++;
        if (rf_we !== 0 || rf_waddr !== 0 || rf_wdata !== 0 || stall_pipe !== 0 || proto_err !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%0b addr=%0d data=%h stall=%0b perr=%0b, expected all 0",
                     rf_we, rf_waddr, rf_wdata, stall_pipe, proto_err);
        end
        checks++;
        if (late_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_late_ready: got %0b expected 1", late_ready);
        end
        @(negedge CLK);
        RESET = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_pipe_only;
        bit acc;
        step(1, 5, 32'hA5A5_0001, 0, 0, 0, acc);
        checks++;
        if (rf_we !== 1 || rf_waddr !== 5 || rf_wdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL pipe_only: got we=%0b reg=%0d data=%h, expected we=1 reg=5 data=a5a50001",
                     rf_we, rf_waddr, rf_wdata);
        end
        step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, acc);
        checks++;
        if (rf_we !== 0 || rf_waddr !== 5 || rf_wdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL pipe_reg0: got we=%0b reg=%0d data=%h, expected we=0 reg=5 data=a5a50001",
                     rf_we, rf_waddr, rf_wdata);
        end
        idle(1);
    endtask

    task automatic test_late_only;
        bit acc;
        step(0, 0, 0, 1, 7, 32'h1234, acc);
        checks++;
        if (!acc || rf_we !== 0) begin
            errors++;
            $display("FAIL late_accept: got acc=%0b we=%0b, expected acc=1 we=0", acc, rf_we);
        end
        step(0, 0, 0, 0, 0, 0, acc);
        checks++;
        if (rf_we !== 1 || rf_waddr !== 7 || rf_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL late_latency: got we=%0b reg=%0d data=%h, expected we=1 reg=7 data=1234",
                     rf_we, rf_waddr, rf_wdata);
        end
        step(0, 0, 0, 0, 0, 0, acc);
        checks++;
        if (rf_we !== 0 || late_ready !== 1) begin
            errors++;
            $display("FAIL late_drained: got we=%0b ready=%0b, expected we=0 ready=1", rf_we, late_ready);
        end
    endtask

    task automatic test_collision;
        bit acc;
        step(1, 3, 32'h0000_0333, 1, 9, 32'h0000_0999, acc);
        checks++;
        if (rf_we !== 1 || rf_waddr !== 3) begin
            errors++;
            $display("FAIL collide_pipe_first: got we=%0b reg=%0d, expected we=1 reg=3", rf_we, rf_waddr);
        end
        step(0, 0, 0, 0, 0, 0, acc);
        checks++;
        if (rf_we !== 1 || rf_waddr !== 9 || rf_wdata !== 32'h0000_0999) begin
            errors++;
            $display("FAIL collide_late_next: got we=%0b reg=%0d data=%h, expected we=1 reg=9 data=999",
                     rf_we, rf_waddr, rf_wdata);
        end
        idle(1);
    endtask

    task automatic test_starvation;
        bit acc;
        bit stalled = 0;
        int n = 0;
        step(1, 1, 32'h100, 1, 11, 32'hBEEF, acc);
        for (int i = 1; i <= 20 && !stalled; i++) begin
            step(1, 1, 32'h100 + i, 0, 0, 0, acc);
            if (stall_pipe === 1'b1) begin
                stalled = 1;
                n = i;
            end
        end
        checks++;
        if (!stalled || n != 8) begin
            errors++;
            $display("FAIL starve_delay: got stall after %0d cycles (seen=%0b), expected 8", n, stalled);
        end
        step(0, 0, 0, 0, 0, 0, acc);
        checks++;
        if (rf_we !== 1 || rf_waddr !== 11 || stall_pipe !== 0 || proto_err !== 0) begin
            errors++;
            $display("FAIL starve_release: got we=%0b reg=%0d stall=%0b perr=%0b, expected 1 11 0 0",
                     rf_we, rf_waddr, stall_pipe, proto_err);
        end
        idle(1);
    endtask

    task automatic test_full;
        bit acc;
        bit got = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 2, 32'h200 + k, 1, 5'(20 + k), 32'hC000 + k, acc);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL full_accept%0d: got acc=0 expected 1", k);
            end
        end
        checks++;
        if (late_ready !== 0) begin
            errors++;
            $display("FAIL full_ready: got %0b expected 0", late_ready);
        end
        step(1, 2, 32'h204, 1, 24, 32'hC004, acc);
        checks++;
        if (acc || stall_pipe !== 1) begin
            errors++;
            $display("FAIL full_stall: got acc=%0b stall=%0b, expected acc=0 stall=1", acc, stall_pipe);
        end
        for (int i = 0; i < 6 && !got; i++) begin
            step(0, 0, 0, 1, 24, 32'hC004, acc);
            if (i == 0) begin
                checks++;
                if (acc || stall_pipe !== 0) begin
                    errors++;
                    $display("FAIL full_unstall: got acc=%0b stall=%0b, expected acc=0 stall=0", acc, stall_pipe);
                end
            end
            got = acc;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL full_fifth_accept: got never accepted, expected accepted");
        end
        idle(8);
        checks++;
        if (late_q.size() != 0 || proto_err !== 0) begin
            errors++;
            $display("FAIL full_drain: got %0d pending perr=%0b, expected 0 pending perr=0",
                     late_q.size(), proto_err);
        end
    endtask

    task automatic test_async_reset_proto;
        bit acc;
        bit stalled = 0;
        for (int k = 0; k < 3; k++) step(1, 4, 32'h400 + k, 1, 5'(30 + k), 32'hD000 + k, acc);
        @(negedge CLK);
        mon_en = 0;
        RESET = 0;
        do_writeback1 = 0; late_valid = 0;
        #1;
        checks++;
        if (rf_we !== 0 || rf_waddr !== 0 || rf_wdata !== 0 || stall_pipe !== 0 ||
            proto_err !== 0 || late_ready !== 1) begin
            errors++;
            $display("FAIL async_reset: got we=%0b addr=%0d data=%h stall=%0b perr=%0b ready=%0b, expected 0 0 0 0 0 1",
                     rf_we, rf_waddr, rf_wdata, stall_pipe, proto_err, late_ready);
        end
        pipe_q.delete();
        late_q.delete();
        @(negedge CLK);
        RESET = 1;
        mon_en = 1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, acc);
            checks++;
            if (rf_we !== 0) begin
                errors++;
                $display("FAIL stale_write%0d: got we=1 reg=%0d, expected we=0", i, rf_waddr);
            end
        end
        step(1, 6, 32'h600, 1, 12, 32'hCCCC, acc);
        for (int i = 0; i < 20 && !stalled; i++) begin
            step(1, 6, 32'h601 + i, 0, 0, 0, acc);
            stalled = (stall_pipe === 1'b1);
        end
        step(1, 6, 32'hDEAD, 0, 0, 0, acc);
        checks++;
        if (proto_err !== 1 || stall_pipe !== 1 || rf_waddr !== 6) begin
            errors++;
            $display("FAIL proto_set: got perr=%0b stall=%0b reg=%0d, expected 1 1 6",
                     proto_err, stall_pipe, rf_waddr);
        end
        step(0, 0, 0, 0, 0, 0, acc);
        checks++;
        if (rf_waddr !== 12 || stall_pipe !== 0 || proto_err !== 1) begin
            errors++;
            $display("FAIL proto_sticky: got reg=%0d stall=%0b perr=%0b, expected 12 0 1",
                     rf_waddr, stall_pipe, proto_err);
        end
        idle(2);
        checks++;
        if (proto_err !== 1 || late_q.size() != 0) begin
            errors++;
            $display("FAIL proto_hold: got perr=%0b pending=%0d, expected 1 0", proto_err, late_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_late_only();
        test_collision();
        test_starvation();
        test_full();
        test_async_reset_proto();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
